// File: rtl/sr_ff.sv
// Single-bit clocked set/reset flip-flop with complementary outputs.
// A parameter selects how S=R=1 resolves: hold, set, reset or toggle.
module sr_ff #(
    parameter logic        RESET_VALUE = 1'b0,
    parameter int unsigned BOTH_MODE   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic Qbar
);

    typedef enum logic [1:0] {
        BOTH_HOLD   = 2'd0,
        BOTH_SET    = 2'd1,
        BOTH_RESET  = 2'd2,
        BOTH_TOGGLE = 2'd3
    } both_mode_t;

    // Values above 3 fall back to hold.
    localparam both_mode_t MODE = (BOTH_MODE > 3) ? BOTH_HOLD : both_mode_t'(BOTH_MODE[1:0]);

    logic next_q;
    logic both_q;

    always_comb begin
        both_q = Q;
        case (MODE)
            BOTH_SET:    both_q = 1'b1;
            BOTH_RESET:  both_q = 1'b0;
            BOTH_TOGGLE: both_q = ~Q;
            default:     both_q = Q;
        endcase
    end

    // NOTE: every branch assigns next_q after the default, so no latch is inferred.
    always_comb begin
        next_q = Q;
        case ({S, R})
            2'b10:   next_q = 1'b1;
            2'b01:   next_q = 1'b0;
            2'b11:   next_q = both_q;
            default: next_q = Q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= next_q;
        end
    end

    // Derived from the single stored bit, so Qbar tracks Q through reset too.
    assign Qbar = ~Q;

endmodule

// File: tb/tb_sr_ff.sv
// Directed testbench for sr_ff: five instances cover every S=R=1 mode,
// an unsupported mode value and a non-zero reset value.
module tb_sr_ff;

    logic       clk = 1'b0;
    logic       rst;
    logic       S;
    logic       R;
    logic [4:0] q_all;
    logic [4:0] qbar_all;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Instances: 0=hold, 1=set-dominant, 2=reset-dominant, 3=toggle,
    // 4=unsupported mode (acts as hold) with RESET_VALUE=1.
    sr_ff #(.RESET_VALUE(1'b0), .BOTH_MODE(0)) u_hold   (.clk(clk), .rst(rst), .S(S), .R(R), .Q(q_all[0]), .Qbar(qbar_all[0]));
    sr_ff #(.RESET_VALUE(1'b0), .BOTH_MODE(1)) u_set    (.clk(clk), .rst(rst), .S(S), .R(R), .Q(q_all[1]), .Qbar(qbar_all[1]));
    sr_ff #(.RESET_VALUE(1'b0), .BOTH_MODE(2)) u_reset  (.clk(clk), .rst(rst), .S(S), .R(R), .Q(q_all[2]), .Qbar(qbar_all[2]));
    sr_ff #(.RESET_VALUE(1'b0), .BOTH_MODE(3)) u_toggle (.clk(clk), .rst(rst), .S(S), .R(R), .Q(q_all[3]), .Qbar(qbar_all[3]));
    sr_ff #(.RESET_VALUE(1'b1), .BOTH_MODE(5)) u_odd    (.clk(clk), .rst(rst), .S(S), .R(R), .Q(q_all[4]), .Qbar(qbar_all[4]));

    task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [4:0] expected);
        check({tag, ".q"}, q_all, expected);
        check({tag, ".qbar"}, qbar_all, ~expected);
    endtask

    typedef struct {
        logic       s;
        logic       r;
        logic [4:0] q;   // expected Q per instance, bit i = instance i
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Hand-computed from start state {odd,tog,rst,set,hold} = 5'b10000.
        vecs[0]  = '{1'b0, 1'b0, 5'b10000};  // hold
        vecs[1]  = '{1'b0, 1'b1, 5'b00000};  // reset
        vecs[2]  = '{1'b1, 1'b0, 5'b11111};  // set
        vecs[3]  = '{1'b1, 1'b1, 5'b10011};  // both: hold/1/0/toggle->0/hold
        vecs[4]  = '{1'b0, 1'b0, 5'b10011};  // hold
        vecs[5]  = '{1'b0, 1'b1, 5'b00000};  // reset
        vecs[6]  = '{1'b1, 1'b1, 5'b01010};  // toggle 0->1
        vecs[7]  = '{1'b1, 1'b1, 5'b00010};  // toggle 1->0
        vecs[8]  = '{1'b1, 1'b1, 5'b01010};  // toggle 0->1
        vecs[9]  = '{1'b1, 1'b0, 5'b11111};  // set
        vecs[10] = '{1'b1, 1'b0, 5'b11111};  // repeated set leaves outputs alone
    end

    initial begin
        logic [4:0] prev_q;

        rst = 1'b1;
        S   = 1'b1;
        R   = 1'b0;
        #1;
        check_outputs("reset_immediate", 5'b10000);
        @(negedge clk);
        check_outputs("reset_beats_set", 5'b10000);

        rst = 1'b0;
        S   = 1'b0;
        prev_q = 5'b10000;
        for (int i = 0; i < 11; i++) begin
            S = vecs[i].s;
            R = vecs[i].r;
            #1;
            check($sformatf("no_comb_path[%0d]", i), q_all, prev_q);
            @(negedge clk);
            check_outputs($sformatf("vec[%0d]", i), vecs[i].q);
            prev_q = vecs[i].q;
        end

        // Asynchronous reset pulse between edges.
        S = 1'b0;
        R = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_reset_mid_cycle", 5'b10000);
        rst = 1'b0;
        S   = 1'b1;
        #1;
        check_outputs("after_release_before_edge", 5'b10000);
        @(negedge clk);
        check_outputs("set_after_release", 5'b11111);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #10000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
